// File: rtl/wb_regfile.sv
// Writeback pipeline register feeding a 32x32 register file with two
// combinational read ports that forward from the execute and writeback stages.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wreg_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              wb_wreg_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0] wb_wdata_o
);

  logic              wb_wreg_r;
  logic [ADDR_W-1:0] wb_waddr_r;
  logic [DATA_W-1:0] wb_wdata_r;
  logic [DATA_W-1:0] regs_r [NREG];
  logic [DATA_W-1:0] rdata1_s;
  logic [DATA_W-1:0] rdata2_s;

  // Youngest result wins: execute stage first, then the pending writeback, then the array.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              rst_v,
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic              ex_we,
    input logic [ADDR_W-1:0] ex_addr,
    input logic [DATA_W-1:0] ex_data,
    input logic              wb_we,
    input logic [ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_data,
    input logic [DATA_W-1:0] arr_data
  );
    logic [DATA_W-1:0] res;
    if (!rst_v) begin
      res = '0;
    end else if (!re) begin
      res = '0;
    end else if (raddr == '0) begin
      res = '0;
    end else if (ex_we && (raddr == ex_addr)) begin
      res = ex_data;
    end else if (wb_we && (raddr == wb_addr)) begin
      res = wb_data;
    end else begin
      res = arr_data;
    end
    return res;
  endfunction

  // Writeback pipeline register: flush beats stall, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wreg_r  <= 1'b0;
      wb_waddr_r <= '0;
      wb_wdata_r <= '0;
    end else if (flush_i) begin
      wb_wreg_r  <= 1'b0;
      wb_waddr_r <= '0;
      wb_wdata_r <= '0;
    end else if (stall_i) begin
      wb_wreg_r  <= wb_wreg_r;
      wb_waddr_r <= wb_waddr_r;
      wb_wdata_r <= wb_wdata_r;
    end else begin
      wb_wreg_r  <= wreg_i;
      wb_waddr_r <= waddr_i;
      wb_wdata_r <= wdata_i;
    end
  end

  // Register array commit from the pending writeback; r0 stays hard-wired to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_wreg_r && (wb_waddr_r != '0)) begin
      regs_r[wb_waddr_r] <= wb_wdata_r;
    end
  end

  // Read port 1 operand selection.
  always_comb begin
    rdata1_s = '0;
    rdata1_s = read_mux(rst, re1_i, raddr1_i, wreg_i, waddr_i, wdata_i,
                        wb_wreg_r, wb_waddr_r, wb_wdata_r, regs_r[raddr1_i]);
  end

  // Read port 2 operand selection.
  always_comb begin
    rdata2_s = '0;
    rdata2_s = read_mux(rst, re2_i, raddr2_i, wreg_i, waddr_i, wdata_i,
                        wb_wreg_r, wb_waddr_r, wb_wdata_r, regs_r[raddr2_i]);
  end

  assign rdata1_o   = rdata1_s;
  assign rdata2_o   = rdata2_s;
  assign wb_wreg_o  = wb_wreg_r;
  assign wb_waddr_o = wb_waddr_r;
  assign wb_wdata_o = wb_wdata_r;

endmodule
